pool_line_buffer: RTL and testbench

POOL_LINE_BUFFER -- requirements
Module: pool_line_buffer

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_line_buffer_if.sv | 45 ++++
 rtl/pool_row_mem.sv | 34 +++
 rtl/pool_line_buffer.sv | 172 +++++++++++++++++
 tb/tb_pool_line_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling pipeline (line buffer and 2x2 max-pool).
//   pool_state_e    : line-buffer FSM state encoding
//   POOL_WORDLENGTH : default signed pixel width used across the pooling stages
// -----------------------------------------------------------------------------
package pool_pkg;

  localparam int POOL_WORDLENGTH = 16;

  // S_EVEN : capturing the even row of a row pair into the row memory
  // S_ODD  : streaming the odd row, emitting (even, odd) column pairs
  // S_GAP  : one idle cycle after every 2-column window so the pooler restarts
  typedef enum logic [1:0] {
    S_EVEN = 2'd0,
    S_ODD  = 2'd1,
    S_GAP  = 2'd2
  } pool_state_e;

endpackage : pool_pkg

// File: rtl/pool_line_buffer_if.sv
// -----------------------------------------------------------------------------
// pool_line_buffer_if
// Pixel stream in / column-pair stream out of the pooling line buffer.
//   in_valid, pixel_in  : raster-order pixel stream (driven by master)
//   in_ready            : line buffer can take pixel_in this cycle
//   out_valid           : pixels_0 / pixels_1 hold a vertical column pair
//   pixels_0, pixels_1  : pixel from even row / odd row of the same column
//   frame_done          : one-cycle pulse with the last pair of a frame
// master = pixel producer / pair consumer side, slave = the line buffer.
// -----------------------------------------------------------------------------
interface pool_line_buffer_if
  import pool_pkg::*;
#(
  parameter int WORDLENGTH = POOL_WORDLENGTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [WORDLENGTH-1:0] pixel_in;
  logic                         out_valid;
  logic signed [WORDLENGTH-1:0] pixels_0;
  logic signed [WORDLENGTH-1:0] pixels_1;
  logic                         frame_done;

  modport master (
    output in_valid,
    output pixel_in,
    input  in_ready,
    input  out_valid,
    input  pixels_0,
    input  pixels_1,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  pixel_in,
    output in_ready,
    output out_valid,
    output pixels_0,
    output pixels_1,
    output frame_done
  );

endinterface : pool_line_buffer_if

// File: rtl/pool_row_mem.sv
// -----------------------------------------------------------------------------
// pool_row_mem
// One feature-map row of storage: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write column, wdata : pixel written
//   raddr : read column,  rdata : pixel at raddr (combinational)
// -----------------------------------------------------------------------------
module pool_row_mem
  import pool_pkg::*;
#(
  parameter  int DEPTH = 28,
  parameter  int WIDTH = POOL_WORDLENGTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; every entry is written in the even
  // row before the odd row reads it, so reset logic would only cost area.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : pool_row_mem

// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// Turns a raster-order pixel stream into vertical column pairs for a 2x2
// max-pool. The even row of each row pair is stored; while the odd row
// streams in, each odd pixel is emitted next to the stored even pixel of the
// same column. After every 2-column window one stall cycle (S_GAP) forces
// out_valid low so the downstream pooler starts a fresh window.
//   clk     : clock, all state on rising edge
//   irst_n  : asynchronous active-low reset
//   clear   : synchronous frame abort, wins over a simultaneous acceptance
//   bus     : pool_line_buffer_if slave (pixel in / pair out / frame_done)
// Parameters: DATA_COL_NUM, ROW_NUM (both even), WORDLENGTH.
// -----------------------------------------------------------------------------
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DATA_COL_NUM = 28,
  parameter int ROW_NUM      = 28,
  parameter int WORDLENGTH   = POOL_WORDLENGTH
) (
  input  logic               clk,
  input  logic               irst_n,
  input  logic               clear,
  pool_line_buffer_if.slave  bus
);

  localparam int ROW_PAIRS = ROW_NUM / 2;
  localparam int COL_W     = (DATA_COL_NUM > 1) ? $clog2(DATA_COL_NUM) : 1;
  localparam int RP_W      = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;

  // Odd geometries would leave a half window or half row pair dangling.
  if ((DATA_COL_NUM % 2) != 0) begin : g_bad_cols
    $error("pool_line_buffer: DATA_COL_NUM must be even");
  end
  if ((ROW_NUM % 2) != 0) begin : g_bad_rows
    $error("pool_line_buffer: ROW_NUM must be even");
  end

  pool_state_e             state, state_nxt;
  logic [COL_W-1:0]        col, col_nxt;
  logic [RP_W-1:0]         row_pair, row_pair_nxt;

  logic                    accept;
  logic                    col_last;
  logic                    row_pair_last;
  logic                    mem_we;
  logic                    pair_load;
  logic                    frame_last;
  logic signed [WORDLENGTH-1:0] even_pixel;

  logic                    out_valid_q;
  logic                    frame_done_q;
  logic signed [WORDLENGTH-1:0] pixels_0_q;
  logic signed [WORDLENGTH-1:0] pixels_1_q;

  assign bus.in_ready   = (state != S_GAP);
  assign accept         = bus.in_valid && bus.in_ready;
  assign col_last       = (col == COL_W'(DATA_COL_NUM - 1));
  assign row_pair_last  = (row_pair == RP_W'(ROW_PAIRS - 1));

  // ---------------------------------------------------------------------------
  // Row memory holding the even row of the current row pair
  // ---------------------------------------------------------------------------
  pool_row_mem #(
    .DEPTH (DATA_COL_NUM),
    .WIDTH (WORDLENGTH)
  ) u_row_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (col),
    .wdata (bus.pixel_in),
    .raddr (col),
    .rdata (even_pixel)
  );

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state    <= S_EVEN;
      col      <= '0;
      row_pair <= '0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row_pair <= row_pair_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counter and datapath-control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt    = state;
    col_nxt      = col;
    row_pair_nxt = row_pair;
    mem_we       = 1'b0;
    pair_load    = 1'b0;
    frame_last   = 1'b0;

    if (clear) begin
      // Abort the frame; any pixel offered this cycle is dropped.
      state_nxt    = S_EVEN;
      col_nxt      = '0;
      row_pair_nxt = '0;
    end else begin
      unique case (state)
        S_EVEN: begin
          if (accept) begin
            mem_we  = 1'b1;
            col_nxt = col_last ? '0 : col + COL_W'(1);
            if (col_last) state_nxt = S_ODD;
          end
        end

        S_ODD: begin
          if (accept) begin
            pair_load = 1'b1;
            col_nxt   = col_last ? '0 : col + COL_W'(1);
            if (col_last) begin
              state_nxt    = S_EVEN;
              row_pair_nxt = row_pair_last ? '0 : row_pair + RP_W'(1);
              frame_last   = row_pair_last;
            end else if (col[0]) begin
              // Second column of a window done: insert the restart gap.
              state_nxt = S_GAP;
            end
          end
        end

        S_GAP: begin
          state_nxt = S_ODD;
        end

        default: begin
          state_nxt = S_EVEN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pair outputs (one-cycle latency from the odd-row acceptance)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pixels_0_q   <= '0;
      pixels_1_q   <= '0;
    end else begin
      out_valid_q  <= pair_load;
      frame_done_q <= frame_last;
      // Pixels hold their last pair whenever nothing new is loaded.
      if (pair_load) begin
        pixels_0_q <= even_pixel;
        pixels_1_q <= bus.pixel_in;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pixels_0   = pixels_0_q;
  assign bus.pixels_1   = pixels_1_q;

endmodule : pool_line_buffer

// File: tb/tb_pool_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_pool_line_buffer
// Directed self-checking bench for pool_line_buffer with a 4x4 frame of
// 16-bit pixels. A negedge monitor records every presented pair; the main
// sequence compares those records and direct samples with hand-computed
// expectations.
// -----------------------------------------------------------------------------
module tb_pool_line_buffer;
  import pool_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int WL   = 16;
  localparam int READY_LIMIT = 8;

  logic clk;
  logic irst_n;
  logic clear;

  pool_line_buffer_if #(.WORDLENGTH(WL)) bus ();

  pool_line_buffer #(
    .DATA_COL_NUM (COLS),
    .ROW_NUM      (ROWS),
    .WORDLENGTH   (WL)
  ) dut (
    .clk    (clk),
    .irst_n (irst_n),
    .clear  (clear),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pairs seen on the output, and what the bench expects to see.
  int got_p0[$];
  int got_p1[$];
  int got_fd[$];
  int exp_p0[$];
  int exp_p1[$];
  int exp_fd[$];
  int stray_fd = 0;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      got_p0.push_back(int'(bus.pixels_0));
      got_p1.push_back(int'(bus.pixels_1));
      got_fd.push_back(bus.frame_done ? 1 : 0);
    end else if (bus.frame_done === 1'b1) begin
      stray_fd++;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel and hold it until accepted (bounded wait on in_ready).
  task automatic push(input int v);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.pixel_in = 16'(v);
    while (bus.in_ready !== 1'b1 && n < READY_LIMIT) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %b, expected 1 within %0d cycles",
               bus.in_ready, READY_LIMIT);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_pair(input int p0, input int p1, input int fd);
    exp_p0.push_back(p0);
    exp_p1.push_back(p1);
    exp_fd.push_back(fd);
  endtask

  // 4x4 frame of 1..16: rows (1..4),(5..8) then (9..12),(13..16).
  task automatic expect_std_frame();
    expect_pair(1, 5, 0);
    expect_pair(2, 6, 0);
    expect_pair(3, 7, 0);
    expect_pair(4, 8, 0);
    expect_pair(9, 13, 0);
    expect_pair(10, 14, 0);
    expect_pair(11, 15, 0);
    expect_pair(12, 16, 1);
  endtask

  task automatic flush_records();
    got_p0.delete();
    got_p1.delete();
    got_fd.delete();
    exp_p0.delete();
    exp_p1.delete();
    exp_fd.delete();
    stray_fd = 0;
  endtask

  task automatic check_pairs(input string tag);
    check({tag, "_pair_count"}, got_p0.size(), exp_p0.size());
    for (int i = 0; i < exp_p0.size() && i < got_p0.size(); i++) begin
      check($sformatf("%s_p0[%0d]", tag, i), got_p0[i], exp_p0[i]);
      check($sformatf("%s_p1[%0d]", tag, i), got_p1[i], exp_p1[i]);
      check($sformatf("%s_fd[%0d]", tag, i), got_fd[i], exp_fd[i]);
    end
    check({tag, "_stray_frame_done"}, stray_fd, 0);
    flush_records();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"},  32'(bus.out_valid),  0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    check({tag, "_pixels_0"},   32'(bus.pixels_0),   0);
    check({tag, "_pixels_1"},   32'(bus.pixels_1),   0);
    check({tag, "_in_ready"},   32'(bus.in_ready),   1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    irst_n       = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.pixel_in = '0;

    // ---- Reset state ----
    #3;
    check_idle_outputs("reset");
    @(posedge clk);
    #1 irst_n = 1'b1;
    tick();

    // ---- Full frame 1..16, gap behaviour around pixel 6 ----
    for (int v = 1; v <= 6; v++) push(v);
    check("gap_in_ready_after_6", 32'(bus.in_ready), 0);
    check("pair_2_6_valid", 32'(bus.out_valid), 1);
    check("pair_2_6_p0", 32'(bus.pixels_0), 2);
    check("pair_2_6_p1", 32'(bus.pixels_1), 6);
    tick();
    check("gap_out_valid_low", 32'(bus.out_valid), 0);
    check("gap_in_ready_back", 32'(bus.in_ready), 1);
    check("gap_pixels_hold_p0", 32'(bus.pixels_0), 2);
    check("gap_pixels_hold_p1", 32'(bus.pixels_1), 6);
    push(7);
    push(8);
    check("row_end_in_ready", 32'(bus.in_ready), 1);
    for (int v = 9; v <= 15; v++) push(v);
    check("frame_done_not_early", 32'(bus.frame_done), 0);
    push(16);
    check("frame_done_pulse", 32'(bus.frame_done), 1);
    check("last_pair_p0", 32'(bus.pixels_0), 12);
    check("last_pair_p1", 32'(bus.pixels_1), 16);
    tick();
    check("frame_done_one_cycle", 32'(bus.frame_done), 0);
    tick();
    expect_std_frame();
    check_pairs("frame1");

    // ---- Stall three cycles after pixel 6 ----
    for (int v = 1; v <= 6; v++) push(v);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_out_valid[%0d]", i), 32'(bus.out_valid), 0);
    end
    for (int v = 7; v <= 16; v++) push(v);
    tick();
    tick();
    expect_std_frame();
    check_pairs("stall");

    // ---- Negative / extreme data, bit-exact ----
    push(-32768); push(-1); push(100); push(-100);
    push(32767);  push(-2); push(-5);  push(7);
    tick();
    tick();
    expect_pair(-32768, 32767, 0);
    expect_pair(-1, -2, 0);
    expect_pair(100, -5, 0);
    expect_pair(-100, 7, 0);
    check_pairs("signed");

    // ---- Clear mid odd row, with a simultaneous offered pixel ----
    for (int v = 50; v <= 54; v++) push(v);
    check("pre_clear_valid", 32'(bus.out_valid), 1);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.pixel_in = 16'(99);
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_out_valid", 32'(bus.out_valid), 0);
    check("clear_frame_done", 32'(bus.frame_done), 0);
    check("clear_in_ready", 32'(bus.in_ready), 1);
    flush_records();
    for (int v = 1; v <= 16; v++) push(v);
    tick();
    tick();
    expect_std_frame();
    check_pairs("after_clear");

    // ---- Asynchronous reset mid-frame ----
    for (int v = 1; v <= 6; v++) push(v);
    check("pre_reset_valid", 32'(bus.out_valid), 1);
    #2 irst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(posedge clk);
    #1 irst_n = 1'b1;
    flush_records();
    for (int v = 1; v <= 16; v++) push(v);
    tick();
    tick();
    expect_std_frame();
    check_pairs("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pool_line_buffer
